// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer for a WIDTH-bit add/subtract that reuses one external 4-bit adder slice, LSB nibble first.
// The result is ready NIB+1 cycles after start. start is ignored while busy; there is no output backpressure.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_cout
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  logic [1:0]           state;
  logic [IDXW-1:0]      idx;
  logic                 carry;
  logic [NIB-1:0][3:0]  a_reg;
  logic [NIB-1:0][3:0]  b_reg;
  logic [NIB-1:0][3:0]  s_nib;
  logic                 run;

  // b_reg holds the effective operand: ~B for subtract, with the +1 supplied as the initial carry
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      s_nib <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= sub;
            idx   <= '0;
            s_nib <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_nib[idx] <= slice_s;
          carry      <= slice_cout;
          idx        <= idx + IDXW'(1);
          if (idx == LAST) begin
            state <= DONE_ST;
            Cout  <= slice_cout;
            Ovf   <= (a_reg[NIB-1][3] == b_reg[NIB-1][3]) && (slice_s[3] != a_reg[NIB-1][3]);
          end
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign run       = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE_ST);
  assign S         = s_nib;
  assign slice_a   = run ? a_reg[idx] : 4'd0;
  assign slice_b   = run ? b_reg[idx] : 4'd0;
  assign slice_cin = run ? carry : 1'b0;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: fixed vectors, multi-cycle corner sequences and random ops against an arithmetic model.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             Clk;
  logic             Reset_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic             slice_cin;
  logic [3:0]       slice_s;
  logic             slice_cout;

  int n_checks = 0;
  int n_errors = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .Ovf(Ovf),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_s(slice_s), .slice_cout(slice_cout)
  );

  // The external slice: plain 4-bit adder with carry
  assign {slice_cout, slice_s} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, no nibble stepping
  task automatic model(input logic op_sub, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic c, output logic o);
    int sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op_sub) begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      r  = a + b;
      c  = ((32'(a) + 32'(b)) > 32'hFFFF);
      sr = sa + sb;
    end
    o = (sr > 32767) || (sr < -32768);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_slice"}, 32'({slice_a, slice_b, slice_cin}), 32'(0));
  endtask

  task automatic run_op(input logic op_sub, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] es, input logic ec, input logic eo, input bit hold);
    int cyc;
    int pulses;
    @(negedge Clk);
    start = 1'b1; sub = op_sub; A = a; B = b;
    @(posedge Clk); #1;
    chk("busy_run", 32'(busy), 32'(1));
    chk("cin_first", 32'(slice_cin), 32'(op_sub));
    chk("slice_a0", 32'(slice_a), 32'(a[3:0]));
    if (hold) begin
      sub = ~op_sub; A = 16'($urandom); B = 16'($urandom);
    end else begin
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge Clk); #1;
      cyc++;
      if (hold) begin
        A = 16'($urandom); B = 16'($urandom);
      end
    end
    chk("latency", 32'(cyc), 32'(NIB));
    chk("result_s", 32'(S), 32'(es));
    chk("cout", 32'(Cout), 32'(ec));
    chk("ovf", 32'(Ovf), 32'(eo));
    pulses = done ? 1 : 0;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (done) pulses++;
    end
    chk("done_pulses", 32'(pulses), 32'(1));
    check_quiet("after");
    chk("s_hold", 32'(S), 32'(es));
  endtask

  initial begin
    logic [15:0] rs;
    logic        rc, ro, rsub;
    logic [15:0] ra, rb;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};

    Reset_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    #1;
    check_quiet("reset");
    chk("reset_s", 32'(S), 32'(0));
    chk("reset_flags", 32'({Cout, Ovf}), 32'(0));
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].op_sub, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].cout, vecs[i].ovf, 1'b0);

    // start and operands churning throughout RUN and DONE must not disturb the result
    run_op(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of pass 2
    @(negedge Clk);
    start = 1'b1; sub = 1'b0; A = 16'hFFFF; B = 16'hFFFF;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("partial_s", 32'(S), 32'(16'h00FE));
    Reset_n = 1'b0;
    #1;
    check_quiet("midreset");
    chk("midreset_s", 32'(S), 32'(0));
    chk("midreset_flags", 32'({Cout, Ovf}), 32'(0));
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rsub = 1'($urandom);
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      if (i % 5 == 0) rb = ra;
      model(rsub, ra, rb, rs, rc, ro);
      run_op(rsub, ra, rb, rs, rc, ro, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
